// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream (base, length, payload) into instruction memory and serves 10-byte fetch windows
module imem_loader #(
   parameter int unsigned MEM_BYTES = 4096,
   parameter int unsigned HDR_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic             reload,
   input  logic [63:0]      rd_addr,
   output logic [79:0]      rd_instr,
   output logic             rd_error,
   output logic             cpu_run,
   output logic             load_done,
   output logic             load_err,
   output logic [HDR_W-1:0] byte_cnt
);
   localparam int unsigned AW = $clog2(MEM_BYTES);
   typedef enum logic [2:0] {HDR_A0, HDR_A1, HDR_L0, HDR_L1, LOAD, DONE} state_t;
   state_t state, state_n;
   logic [7:0] hi;
   logic [HDR_W-1:0] len, hdr;
   logic [HDR_W:0] wptr;
   logic xfer, wr_ok, last;
   logic [7:0] mem [MEM_BYTES];
   assign in_ready = rst_n & (state != DONE);
   assign xfer = in_valid & in_ready;
   assign cpu_run = state == DONE;
   assign hdr = HDR_W'({hi, in_data});
   assign wr_ok = 32'(wptr) < MEM_BYTES;
   assign last = byte_cnt == len - HDR_W'(1);
   always_comb begin
      state_n = state;
      case (state)
         HDR_A0:  if (xfer) state_n = HDR_A1;
         HDR_A1:  if (xfer) state_n = HDR_L0;
         HDR_L0:  if (xfer) state_n = HDR_L1;
         HDR_L1:  if (xfer) state_n = (hdr == '0) ? DONE : LOAD;
         LOAD:    if (xfer && last) state_n = DONE;
         DONE:    if (reload) state_n = HDR_A0;
         default: state_n = HDR_A0;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HDR_A0;
         hi        <= '0;
         len       <= '0;
         wptr      <= '0;
         byte_cnt  <= '0;
         load_err  <= 1'b0;
         load_done <= 1'b0;
      end else begin
         state     <= state_n;
         load_done <= (state_n == DONE) && (state != DONE);
         if (xfer) begin
            case (state)
               HDR_A0, HDR_L0: hi <= in_data;
               HDR_A1: wptr <= {1'b0, hdr};
               HDR_L1: begin
                  len      <= hdr;
                  byte_cnt <= '0;
               end
               LOAD: begin
                  // out-of-range bytes are still consumed so the stream stays framed
                  wptr     <= wptr + (HDR_W+1)'(1);
                  byte_cnt <= byte_cnt + HDR_W'(1);
                  if (!wr_ok) load_err <= 1'b1;
               end
               default: ;
            endcase
         end
         if (state == DONE && reload) begin
            byte_cnt <= '0;
            load_err <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk)
      if (xfer && state == LOAD && wr_ok) mem[AW'(wptr)] <= in_data;
   // 65-bit compares so a fetch near 2^64 reports out of range instead of wrapping
   always_comb begin
      rd_instr = '0;
      for (int k = 0; k < 10; k++)
         if ({1'b0, rd_addr} + 65'(k) < 65'(MEM_BYTES))
            rd_instr[79-8*k -: 8] = mem[AW'(rd_addr + 64'(k))];
   end
   assign rd_error = {1'b0, rd_addr} + 65'd9 >= 65'(MEM_BYTES);
endmodule
